fake_mario_key_conditioner: RTL and testbench
=============================================

Name: fake_mario_key_conditioner

Overview:
Upstream conditioning stage for the push-button PIO input. It conditions the raw board push-buttons before they reach the PIO `in_port`:
- 2-FF synchronization into the `clk` domain
- per-key counter-based debounce
- polarity normalization to active-high "pressed"

`key_level` drives the PIO `in_port` directly. `key_press`/`key_release` are single-cycle pulses for game logic that needs edges rather than levels.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range 1..2^24-1.
- RAW_ACTIVE_LOW, 1, 1 means a pressed key drives raw 0 (board buttons); 0 means raw 1 = pressed.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset; deassertion is synchronized externally.
- key_raw, input, NUM_KEYS, asynchronous button pins.
- key_level, output, NUM_KEYS, debounced state, 1 = pressed; connects to the PIO `in_port`.
- key_press, output, NUM_KEYS, 1-cycle pulse on an accepted released->pressed transition.
- key_release, output, NUM_KEYS, 1-cycle pulse on an accepted pressed->released transition.

Behaviour:
- Reset (async, reset_n=0):
  - sync FFs = idle raw level (1 if RAW_ACTIVE_LOW, else 0);
  - key_level = 0, counters = 0, key_press = 0, key_release = 0.
- Synchronizer: 2 flops per key, so sync2 reflects key_raw after 2 rising edges. The polarity inversion (RAW_ACTIVE_LOW) is applied after sync2, giving `s` (1 = pressed).
- Per-key counter CNT_W = clog2(DEBOUNCE_CYCLES+1) bits, evaluated each edge:
  - if s == key_level: counter <= 0, no pulse;
  - else if counter == DEBOUNCE_CYCLES-1: key_level <= s, counter <= 0, and key_press <= s or key_release <= ~s on that same edge;
  - else: counter <= counter+1.
- Latency: a clean step on key_raw just before edge 0 changes key_level, with its pulse, at edge 2+DEBOUNCE_CYCLES. The pulse is high for exactly one cycle.
- Bounce: any cycle in which s returns to key_level clears the counter, and the full DEBOUNCE_CYCLES window restarts.
- No wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES=1: key_level follows s with 1 cycle of added delay (3 edges total); every accepted change still pulses.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses in the same cycle.
- key_press and key_release are never both high on the same key.
- Reset mid-count: all state clears immediately. After release from reset a held key is re-qualified from scratch and produces a fresh key_press.
- All outputs are registered; there is no combinational path from key_raw.

Decomposition:
- Package fake_mario_key_pkg holds:
  - NUM_KEYS_DEFAULT = 4
  - DEBOUNCE_10MS_50MHZ = 500000
  - the CNT_W function (clog2)
- One sub-module, fake_mario_key_debounce_ch, implements one channel: sync, counter, level and pulse outputs.
- The top generates NUM_KEYS instances and concatenates their outputs.

Test Plan (DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=1, NUM_KEYS=4):
1. Reset with key_raw=4'hF, then hold -> key_level=0, key_press=0 and key_release=0 for 20 cycles.
2. key_raw 4'hF->4'hE held -> key_level=4'h1 and key_press=4'h1 at edge 6 exactly; key_press=0 at edge 7.
3. key_raw[0] glitches low for 3 cycles, then high; repeat 5 times -> key_level stays 0, no pulses ever.
4. Key 0 pressed and stable, then key_raw[0]=1 -> key_release=4'h1 pulse for one cycle; key_level returns to 0 six edges after the change.
5. key_raw 4'hF->4'h5 on the same edge -> key_press=4'hA and key_level=4'hA in the same cycle.
6. Hold key 2 and assert reset_n=0 mid-count (counter=2), then release reset -> outputs 0 during reset; key_press[2] fires 6 edges after reset_n rises.

Source files
------------

// File: rtl/fake_mario_key_pkg.sv
// Shared constants and helpers for the push-button conditioning stage.
package fake_mario_key_pkg;

    localparam int unsigned NUM_KEYS_DEFAULT    = 4;
    localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

    // Counter width able to hold every value up to and including cycles.
    function automatic int unsigned cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/fake_mario_key_debounce_ch.sv
// One key channel: 2-FF synchronizer, polarity normalisation, counter
// debounce, debounced level and single-cycle press/release pulses.
module fake_mario_key_debounce_ch
    import fake_mario_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned          CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic                 IDLE_RAW = RAW_ACTIVE_LOW;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             s_q, s_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic: synchronizer shift, polarity fix and debounce counter.
    // The normalised sample is held in its own flop so a clean step reaches
    // key_level at edge 2+DEBOUNCE_CYCLES.
    always_comb begin
        sync1_d   = key_raw;
        sync2_d   = sync1_q;
        s_d       = sync2_q ^ RAW_ACTIVE_LOW;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        cnt_d     = cnt_q;
        if (s_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d   = s_q;
            cnt_d     = '0;
            press_d   = s_q;
            release_d = ~s_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset parks the synchronizer at the idle raw level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= IDLE_RAW;
            sync2_q   <= IDLE_RAW;
            s_q       <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            s_q       <= s_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/fake_mario_key_conditioner.sv
// Push-button conditioner: one independent debounce channel per key,
// outputs concatenated bit-per-key for the PIO in_port and game logic.
module fake_mario_key_conditioner
    import fake_mario_key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = NUM_KEYS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        fake_mario_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[k]),
            .key_level   (key_level[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k])
        );
    end

endmodule

// File: tb/tb_fake_mario_key_conditioner.sv
// Self-checking bench: directed test-plan steps followed by random key
// activity, checked against a sliding-window reference model. A second
// instance covers DEBOUNCE_CYCLES=1 with active-high raw polarity.
module tb_fake_mario_key_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] lvl_a, prs_a, rel_a;
    logic [3:0] lvl_b, prs_b, rel_b;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: hist[i][m] is the raw vector present before the edge
    // m edges ago. A key's debounced view of edge t is raw from edge t-3;
    // a change is accepted once D consecutive views disagree with the level.
    logic [3:0]  hist  [2][8];
    logic [3:0]  m_lvl [2];
    logic [3:0]  m_prs [2];
    logic [3:0]  m_rel [2];
    int unsigned dcy   [2] = '{4, 1};
    bit          al    [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    fake_mario_key_conditioner #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .RAW_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (lvl_a),
        .key_press   (prs_a),
        .key_release (rel_a)
    );

    fake_mario_key_conditioner #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (1),
        .RAW_ACTIVE_LOW  (1'b0)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (lvl_b),
        .key_press   (prs_b),
        .key_release (rel_b)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 8; m++) hist[i][m] = al[i] ? 4'hF : 4'h0;
            m_lvl[i] = 4'h0;
            m_prs[i] = 4'h0;
            m_rel[i] = 4'h0;
        end
    endtask

    task automatic model_edge(input logic [3:0] raw);
        for (int i = 0; i < 2; i++) begin
            for (int m = 7; m > 0; m--) hist[i][m] = hist[i][m-1];
            hist[i][0] = raw;
            m_prs[i] = 4'h0;
            m_rel[i] = 4'h0;
            for (int k = 0; k < 4; k++) begin
                bit acc = 1'b1;
                for (int j = 0; j < int'(dcy[i]); j++) begin
                    logic p;
                    p = hist[i][3+j][k] ^ al[i];
                    if (p == m_lvl[i][k]) acc = 1'b0;
                end
                if (acc) begin
                    m_lvl[i][k] = ~m_lvl[i][k];
                    m_prs[i][k] = m_lvl[i][k];
                    m_rel[i][k] = ~m_lvl[i][k];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("level_a",   lvl_a, m_lvl[0]);
        chk("press_a",   prs_a, m_prs[0]);
        chk("release_a", rel_a, m_rel[0]);
        chk("level_b",   lvl_b, m_lvl[1]);
        chk("press_b",   prs_b, m_prs[1]);
        chk("release_b", rel_b, m_rel[1]);
        chk("excl_a",    prs_a & rel_a, 4'h0);
        chk("excl_b",    prs_b & rel_b, 4'h0);
    endtask

    // One rising edge with key_raw held; compares just after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge(key_raw);
        #1;
        check_all();
    endtask

    task automatic enter_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_level_a", lvl_a, 4'h0);
        chk("rst_press_a", prs_a, 4'h0);
        chk("rst_rel_a",   rel_a, 4'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        key_raw = 4'hF;
        model_reset();

        // 1: reset with all keys idle, then hold for 20 cycles
        repeat (3) @(posedge clk);
        #1;
        enter_reset();
        tick();
        reset_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            chk("t1_level", lvl_a, 4'h0);
            chk("t1_press", prs_a, 4'h0);
            chk("t1_rel",   rel_a, 4'h0);
        end

        // 2: press key 0, accepted at edge 6 only
        key_raw = 4'hE;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 5) chk("t2_level_e5", lvl_a, 4'h0);
            if (e == 6) begin
                chk("t2_level_e6", lvl_a, 4'h1);
                chk("t2_press_e6", prs_a, 4'h1);
            end
            if (e == 7) chk("t2_press_e7", prs_a, 4'h0);
        end

        // 4: release key 0, release pulse and level drop at edge 6
        key_raw = 4'hF;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 5) chk("t4_level_e5", lvl_a, 4'h1);
            if (e == 6) begin
                chk("t4_level_e6", lvl_a, 4'h0);
                chk("t4_rel_e6",   rel_a, 4'h1);
            end
            if (e == 7) chk("t4_rel_e7", rel_a, 4'h0);
        end

        // 3: five 3-cycle glitches on key 0 never qualify
        for (int g = 0; g < 5; g++) begin
            key_raw = 4'hE;
            repeat (3) begin
                tick();
                chk("t3_level", lvl_a, 4'h0);
                chk("t3_press", prs_a, 4'h0);
            end
            key_raw = 4'hF;
            repeat (2) begin
                tick();
                chk("t3_level", lvl_a, 4'h0);
                chk("t3_press", prs_a, 4'h0);
            end
        end
        repeat (6) tick();

        // 5: keys 1 and 3 together
        key_raw = 4'h5;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 6) begin
                chk("t5_press", prs_a, 4'hA);
                chk("t5_level", lvl_a, 4'hA);
            end
        end
        key_raw = 4'hF;
        repeat (10) tick();

        // 6: reset while key 2 is mid-qualification, then requalify
        key_raw = 4'hB;
        repeat (5) tick();
        enter_reset();
        repeat (3) begin
            tick();
            chk("t6_rst_level", lvl_a, 4'h0);
        end
        reset_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick();
            if (e == 5) chk("t6_press_e5", prs_a, 4'h0);
            if (e == 6) chk("t6_press_e6", prs_a, 4'h4);
        end

        // Random key activity with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) key_raw = key_raw ^ 4'($urandom_range(15));
            if ($urandom_range(400) == 0) begin
                enter_reset();
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
